// File: rtl/ncl_rx_sync.sv
// ncl_rx_sync
// Receiving end of a dual-rail NCL four-phase channel. Every input rail is
// synchronised into the clock domain. Each completed DATA wavefront is
// acknowledged through ko and turned into a single-rail word. Words are
// buffered in a first-word-fall-through FIFO and presented on a valid/ready
// stream.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   d_t      in   [WIDTH] true rails  (DATA1 = t1/f0)
//   d_f      in   [WIDTH] false rails (DATA0 = t0/f1, NULL = t0/f0)
//   ko       out  1 = request-for-DATA, 0 = request-for-NULL
//   m_data   out  [WIDTH] word at the FIFO head (true rails of the wavefront)
//   m_valid  out  FIFO not empty
//   m_ready  in   consumer pops the head when m_valid & m_ready at an edge
//   err      out  sticky illegal-code flag
//
// Optional feature macro: NCL_RX_ERR_CHECK_EN
//   When defined, a bit with both rails high sets err and blocks capture.
//   A bit that returns to NULL and re-asserts before the whole word is NULL
//   also sets err. When undefined, err is tied low.

module ncl_rx_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_t,
  input  logic [WIDTH-1:0] d_f,
  output logic             ko,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [0:0] {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  state_t state_q, next_state;

  logic [WIDTH-1:0] sync_t [SYNC_STAGES];
  logic [WIDTH-1:0] sync_f [SYNC_STAGES];
  logic [WIDTH-1:0] s_t, s_f, rails_set;
  logic             complete, null_wf;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, rd_next;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full, empty, pop, fifo_wr;

  // Rail synchronisers. Rails are monotonic within a phase, so skew between
  // bits can only delay completion and can never produce a false word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_t[s] <= '0;
        sync_f[s] <= '0;
      end
    end else begin
      sync_t[0] <= d_t;
      sync_f[0] <= d_f;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_t[s] <= sync_t[s-1];
        sync_f[s] <= sync_f[s-1];
      end
    end
  end

  assign s_t       = sync_t[SYNC_STAGES-1];
  assign s_f       = sync_f[SYNC_STAGES-1];
  assign rails_set = s_t | s_f;
  assign null_wf   = (rails_set == '0);

`ifdef NCL_RX_ERR_CHECK_EN
  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] nulled_q;
  logic             err_q;

  assign illegal  = s_t & s_f;
  assign complete = (&rails_set) && !(|illegal);

  // Sticky error detection. nulled_q remembers which bits have already gone
  // back to NULL during the current NULL phase. A rail rising again on such
  // a bit before the full NULL is a protocol violation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      nulled_q <= '0;
    end else begin
      if (|illegal)
        err_q <= 1'b1;
      if (state_q == WAIT_NULL) begin
        if (|(nulled_q & rails_set))
          err_q <= 1'b1;
        if (null_wf)
          nulled_q <= '0;
        else
          nulled_q <= nulled_q | ~rails_set;
      end else begin
        nulled_q <= '0;
      end
    end
  end

  assign err = err_q;
`else
  assign complete = &rails_set;
  assign err      = 1'b0;
`endif

  // FIFO status. Pointers carry one extra wrap bit so that full and empty
  // can be told apart.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && m_ready;
  assign rd_next = rd_ptr + PTR_ONE;
  assign m_valid = !empty;
  assign m_data  = head_q;

  // Handshake FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= WAIT_DATA;
    else
      state_q <= next_state;
  end

  // Next-state logic and outputs. A pop in the same cycle frees a slot, so a
  // full FIFO can still accept the capture on that edge.
  always_comb begin
    next_state = state_q;
    fifo_wr    = 1'b0;
    ko         = 1'b1;
    case (state_q)
      WAIT_DATA: begin
        if (complete && (!full || pop)) begin
          fifo_wr    = 1'b1;
          next_state = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        ko = 1'b0;
        if (null_wf)
          next_state = WAIT_DATA;
      end
      default: next_state = WAIT_DATA;
    endcase
  end

  // Next head word. On a pop the following entry moves to the head. If the
  // entry being popped is the last one, the word written on the same edge
  // becomes the head. A write into an empty FIFO falls straight through.
  always_comb begin
    head_d = head_q;
    if (pop) begin
      if (rd_next == wr_ptr) begin
        if (fifo_wr)
          head_d = s_t;
      end else begin
        head_d = mem[rd_next[AW-1:0]];
      end
    end else if (empty && fifo_wr) begin
      head_d = s_t;
    end
  end

  // Pointer and head register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= '0;
    end else begin
      head_q <= head_d;
      if (fifo_wr)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_next;
    end
  end

  // Storage array. It needs no reset because empty entries are never read.
  always_ff @(posedge clk) begin
    if (fifo_wr)
      mem[wr_ptr[AW-1:0]] <= s_t;
  end

endmodule

// File: tb/tb_ncl_rx_sync.sv
// tb_ncl_rx_sync
// Self-checking bench for ncl_rx_sync. It acts as an NCL sender and as a
// stream consumer. The expected word order is kept in a queue. A word joins
// the queue when the receiver acknowledges it, and the queue is checked
// against m_data on every pop.
// Optional feature macro: NCL_RX_ERR_CHECK_EN (changes the expected err).

module tb_ncl_rx_sync;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int D  = 4;

`ifdef NCL_RX_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] d_t, d_f;
  logic         ko;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         err;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] cur_word;
  logic         prev_ko;
  logic         err_exp;
  int           rdy_mode;   // 0 = never ready, 1 = always ready, 2 = random
  logic [W-1:0] w;
  logic [W-1:0] r[6];

  ncl_rx_sync #(.WIDTH(W), .SYNC_STAGES(SS), .FIFO_DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_t     (d_t),
    .d_f     (d_f),
    .ko      (ko),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .err     (err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] t, input logic [W-1:0] f);
    d_t = t;
    d_f = f;
  endtask

  // Advance one cycle, then act at the falling edge. Record an acknowledge
  // as a captured word and check valid and err against the model. Choose
  // m_ready for the next edge and check the word that edge will pop.
  task automatic step();
    logic [W-1:0] expw;
    @(negedge clk);
    if (prev_ko === 1'b1 && ko === 1'b0) begin
      q.push_back(cur_word);
      checkOutput("fifo overflow", q.size() <= D, 1);
    end
    prev_ko = ko;
    checkOutput("m_valid", m_valid, q.size() != 0);
    checkOutput("err", err, err_exp);
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    if (m_ready && q.size() != 0) begin
      expw = q.pop_front();
      checkOutput("m_data pop", m_data, expw);
    end
  endtask

  task automatic waitKo(input logic val, input string tag);
    int n = 0;
    while (ko !== val && n < 300) begin
      step();
      n++;
    end
    checkOutput(tag, ko, val);
  endtask

  task automatic sendWord(input logic [W-1:0] wd);
    cur_word = wd;
    applyStimulus(wd, ~wd);
    waitKo(1'b0, "ko ack data");
    applyStimulus('0, '0);
    waitKo(1'b1, "ko ack null");
  endtask

  initial begin
    rst_n    = 1'b0;
    m_ready  = 1'b0;
    rdy_mode = 0;
    err_exp  = 1'b0;
    prev_ko  = 1'b1;
    cur_word = '0;
    applyStimulus('0, '0);

    // Reset state
    #12;
    checkOutput("reset ko", ko, 1);
    checkOutput("reset m_valid", m_valid, 0);
    checkOutput("reset m_data", m_data, 0);
    checkOutput("reset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single word with exact latency in both directions
    $display("[TB] test 1: single word");
    cur_word = 4'hA;
    applyStimulus(4'b1010, 4'b0101);
    for (int k = 1; k <= SS + 1; k++) begin
      step();
      checkOutput("t1 ko fall timing", ko, (k <= SS) ? 1 : 0);
    end
    checkOutput("t1 m_data", m_data, 4'hA);
    applyStimulus('0, '0);
    for (int k = 1; k <= SS + 1; k++) begin
      step();
      checkOutput("t1 ko rise timing", ko, (k <= SS) ? 0 : 1);
    end
    rdy_mode = 1;
    repeat (3) step();

    // 2: skewed arrival; only the final bit completes the word
    $display("[TB] test 2: skew");
    rdy_mode = 0;
    cur_word = 4'h0;
    applyStimulus(4'h0, 4'b0001);
    repeat (10) step();
    checkOutput("t2 partial no capture", ko, 1);
    applyStimulus(4'h0, 4'hF);
    waitKo(1'b0, "t2 ko after complete");
    checkOutput("t2 m_data", m_data, 4'h0);
    applyStimulus('0, '0);
    waitKo(1'b1, "t2 ko after null");
    rdy_mode = 1;
    repeat (3) step();

    // 3: backpressure, fifth word waits for space
    $display("[TB] test 3: backpressure");
    rdy_mode = 0;
    for (int i = 1; i <= 4; i++) sendWord(4'(i));
    cur_word = 4'd5;
    applyStimulus(4'd5, ~4'd5);
    repeat (SS + 4) step();
    checkOutput("t3 ko held while full", ko, 1);
    rdy_mode = 1;
    step();
    step();
    checkOutput("t3 capture on pop edge", ko, 0);
    applyStimulus('0, '0);
    waitKo(1'b1, "t3 ko after null");
    repeat (5) step();

    // 4: single-cycle pop while full coincides with the capture
    $display("[TB] test 4: pop and capture while full");
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) r[i] = W'($urandom);
    for (int i = 0; i < 4; i++) sendWord(r[i]);
    cur_word = r[4];
    applyStimulus(r[4], ~r[4]);
    repeat (SS + 2) step();
    checkOutput("t4 ko held while full", ko, 1);
    rdy_mode = 1;
    step();
    rdy_mode = 0;
    step();
    checkOutput("t4 capture on pop edge", ko, 0);
    applyStimulus('0, '0);
    waitKo(1'b1, "t4 ko after null");
    cur_word = r[5];
    applyStimulus(r[5], ~r[5]);
    repeat (SS + 4) step();
    checkOutput("t4 still full", ko, 1);
    rdy_mode = 1;
    waitKo(1'b0, "t4 late capture");
    applyStimulus('0, '0);
    waitKo(1'b1, "t4 ko after null 2");
    repeat (6) step();

    // 5: asynchronous reset in the middle of a DATA phase
    $display("[TB] test 5: reset mid-data");
    rdy_mode = 0;
    w = W'($urandom);
    cur_word = w;
    applyStimulus(w, ~w);
    waitKo(1'b0, "t5 ko before reset");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5 async ko", ko, 1);
    checkOutput("t5 async m_valid", m_valid, 0);
    checkOutput("t5 async m_data", m_data, 0);
    q.delete();
    prev_ko = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= SS + 1; k++) begin
      step();
      checkOutput("t5 recapture timing", ko, (k <= SS) ? 1 : 0);
    end
    checkOutput("t5 recapture m_data", m_data, w);
    applyStimulus('0, '0);
    waitKo(1'b1, "t5 ko after null");
    rdy_mode = 1;
    repeat (3) step();

    // Randomised traffic with a randomly stalling consumer
    $display("[TB] random traffic");
    rdy_mode = 2;
    for (int i = 0; i < 24; i++) sendWord(W'($urandom));
    rdy_mode = 1;
    repeat (8) step();

    // 6: both rails high on one bit
    $display("[TB] test 6: illegal code");
    rdy_mode = 0;
    m_ready  = 1'b0;
    applyStimulus(4'b0001, 4'b0001);
    repeat (SS + 1) @(negedge clk);
    checkOutput("t6 err", err, ERR_EN);
    repeat (4) @(negedge clk);
    checkOutput("t6 ko", ko, 1);
    checkOutput("t6 no write", m_valid, 0);
    err_exp = ERR_EN;
    applyStimulus('0, '0);
    repeat (SS + 2) step();
    sendWord(4'h6);
    rdy_mode = 1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
